// File: rtl/core_ctrl_if.sv
// Host/controller bundle for core_ctrl: tile request/completion, Q/K row-write
// handshake, output-FIFO status and the 17-bit core instruction word.
interface core_ctrl_if;
    logic        start;
    logic [4:0]  num_q;
    logic        wr_valid;
    logic        wr_ready;
    logic        fifo_valid;
    logic [16:0] inst;
    logic        busy;
    logic        done;
    logic        rb_valid;

    modport master (
        output start, num_q, wr_valid, fifo_valid,
        input  wr_ready, inst, busy, done, rb_valid
    );

    modport slave (
        input  start, num_q, wr_valid, fifo_valid,
        output wr_ready, inst, busy, done, rb_valid
    );
endinterface

// File: rtl/core_ctrl.sv
// Attention-tile instruction sequencer for core: Q load, K load, kernel load,
// execute, FIFO drain. Define CORE_CTRL_READBACK_EN to add the psum readback phase.
module core_ctrl #(
    parameter int col    = 8,
    parameter int addr_w = 4
) (
    input  logic        clk,
    input  logic        reset,
    core_ctrl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_Q,
        S_LOAD_K,
        S_KARR,
        S_EXEC,
        S_DRAIN,
        S_OFIFO,
`ifdef CORE_CTRL_READBACK_EN
        S_RDBK,
`endif
        S_DONE
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [4:0]  nq, nq_nx;
    logic [16:0] inst;
    logic        wr_ready;
    logic [3:0]  addr;
    logic        nq_last;
    logic        col_last;

    assign addr     = 4'(cnt[addr_w-1:0]);
    assign nq_last  = (cnt == nq - 5'd1);
    assign col_last = (cnt == 5'(col - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
            nq    <= 5'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            nq    <= nq_nx;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        nq_nx    = nq;
        inst     = 17'd0;
        wr_ready = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    nq_nx    = bus.num_q;
                    cnt_nx   = 5'd0;
                    state_nx = (bus.num_q == 5'd0) ? S_DONE : S_LOAD_Q;
                end
            end
            S_LOAD_Q: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    inst[4]     = 1'b1;
                    inst[15:12] = addr;
                    cnt_nx      = nq_last ? 5'd0 : cnt + 5'd1;
                    if (nq_last) state_nx = S_LOAD_K;
                end
            end
            S_LOAD_K: begin
                wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    inst[2]     = 1'b1;
                    inst[15:12] = addr;
                    cnt_nx      = col_last ? 5'd0 : cnt + 5'd1;
                    if (col_last) state_nx = S_KARR;
                end
            end
            S_KARR: begin
                inst[6]     = 1'b1;
                inst[3]     = 1'b1;
                inst[15:12] = addr;
                cnt_nx      = col_last ? 5'd0 : cnt + 5'd1;
                if (col_last) state_nx = S_EXEC;
            end
            S_EXEC: begin
                inst[7]     = 1'b1;
                inst[5]     = 1'b1;
                inst[15:12] = addr;
                cnt_nx      = nq_last ? 5'd0 : cnt + 5'd1;
                if (nq_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (bus.fifo_valid) begin
                    cnt_nx   = 5'd0;
                    state_nx = S_OFIFO;
                end
            end
            S_OFIFO: begin
                // A FIFO stall freezes cnt so no psum address is skipped.
                if (bus.fifo_valid) begin
                    inst[16]   = 1'b1;
                    inst[0]    = 1'b1;
                    inst[11:8] = addr;
                    cnt_nx     = nq_last ? 5'd0 : cnt + 5'd1;
`ifdef CORE_CTRL_READBACK_EN
                    if (nq_last) state_nx = S_RDBK;
`else
                    if (nq_last) state_nx = S_DONE;
`endif
                end
            end
`ifdef CORE_CTRL_READBACK_EN
            S_RDBK: begin
                inst[1]    = 1'b1;
                inst[11:8] = addr;
                cnt_nx     = nq_last ? 5'd0 : cnt + 5'd1;
                if (nq_last) state_nx = S_DONE;
            end
`endif
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef CORE_CTRL_READBACK_EN
    // Read data appears one cycle after the pmem read enable.
    logic rb_q;
    always_ff @(posedge clk) begin
        if (reset) rb_q <= 1'b0;
        else       rb_q <= (state == S_RDBK);
    end
    assign bus.rb_valid = rb_q;
`else
    assign bus.rb_valid = 1'b0;
`endif

    assign bus.inst     = inst;
    assign bus.wr_ready = wr_ready;
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = (state == S_DONE);

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: stimulus pushes the expected non-idle cycles,
// a negedge monitor pops and compares them.
module tb_core_ctrl;
    localparam int COL = 8;
`ifdef CORE_CTRL_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    typedef struct {
        logic [16:0] inst;
        logic        done;
        logic        rb;
    } exp_t;

    logic clk;
    logic reset;
    core_ctrl_if bus();

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    core_ctrl #(.col(COL), .addr_w(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with activity on inst/done/rb_valid must match the queue head.
    always @(negedge clk) begin
        if (!reset && (bus.inst != 17'd0 || bus.done || bus.rb_valid)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL seq: got inst=0x%05h done=%b rb=%b, expected nothing", bus.inst, bus.done, bus.rb_valid);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("seq", {13'd0, bus.inst, bus.done, bus.rb_valid}, {13'd0, e.inst, e.done, e.rb});
            end
        end
    end

    task automatic push(input logic [16:0] inst, input logic done, input logic rb);
        exp_t e;
        e.inst = inst;
        e.done = done;
        e.rb   = rb;
        exp_q.push_back(e);
    endtask

    task automatic push_tile(input int n);
        if (n == 0) begin
            push(17'd0, 1'b1, 1'b0);
            return;
        end
        for (int i = 0; i < n; i++)   push(17'h00010 | (17'(i) << 12), 1'b0, 1'b0);
        for (int i = 0; i < COL; i++) push(17'h00004 | (17'(i) << 12), 1'b0, 1'b0);
        for (int i = 0; i < COL; i++) push(17'h00048 | (17'(i) << 12), 1'b0, 1'b0);
        for (int i = 0; i < n; i++)   push(17'h000A0 | (17'(i) << 12), 1'b0, 1'b0);
        for (int i = 0; i < n; i++)   push(17'h10001 | (17'(i) << 8), 1'b0, 1'b0);
        if (RB == 1) begin
            for (int i = 0; i < n; i++) push(17'h00002 | (17'(i) << 8), 1'b0, (i > 0));
            push(17'd0, 1'b1, 1'b1);
        end else begin
            push(17'd0, 1'b1, 1'b0);
        end
    endtask

    function automatic int exp_latency(input int n);
        if (n == 0) return 1;
        return 3 * n + 2 * COL + 2 + RB * n;
    endfunction

    task automatic run_tile(input int n, input bit wr_toggle, input bit fifo_stall,
                            input bit busy_start, input int exp_lat);
        int cyc;
        int rows;
        int stall_left;
        bit got;
        rows       = 0;
        stall_left = fifo_stall ? 3 : 0;
        got        = 1'b0;
        push_tile(n);
        bus.start = 1'b1;
        bus.num_q = 5'(n);
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.num_q = 5'd0;
        cyc = 1;
        while (cyc <= 400) begin
            bus.wr_valid = wr_toggle ? (cyc % 2 == 1) : 1'b1;
            if (fifo_stall && rows == 2 && stall_left > 0) begin
                bus.fifo_valid = 1'b0;
                stall_left--;
            end else begin
                bus.fifo_valid = 1'b1;
            end
            if (busy_start && cyc == 3) begin
                bus.start = 1'b1;
                bus.num_q = 5'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            if (busy_start && cyc == 3) check("busy_during_tile", 32'(bus.busy), 32'd1);
            if (bus.inst[16]) rows++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: no done within 400 cycles for num_q=%0d", n);
        end else if (exp_lat >= 0) begin
            check("latency", 32'(cyc), 32'(exp_lat));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_wr_ready", 32'(bus.wr_ready), 32'd0);
    endtask

    task automatic reset_mid_exec();
        bit seen;
        seen = 1'b0;
        push_tile(4);
        bus.start = 1'b1;
        bus.num_q = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.inst[7]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL exec_timeout: EXEC never reached before reset");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_inst", 32'(bus.inst), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.num_q      = 5'd0;
        bus.wr_valid   = 1'b0;
        bus.fifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_inst", 32'(bus.inst), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rb_valid", 32'(bus.rb_valid), 32'd0);
        @(posedge clk); #1;

        run_tile(4, 1'b0, 1'b0, 1'b0, exp_latency(4));   // nominal tile
        run_tile(4, 1'b1, 1'b0, 1'b0, -1);               // write backpressure
        run_tile(4, 1'b0, 1'b1, 1'b0, exp_latency(4) + 3); // FIFO stall
        run_tile(0, 1'b0, 1'b0, 1'b0, exp_latency(0));   // empty tile
        run_tile(16, 1'b0, 1'b0, 1'b0, exp_latency(16)); // full depth
        run_tile(5, 1'b0, 1'b0, 1'b1, exp_latency(5));   // start while busy
        reset_mid_exec();
        @(posedge clk); #1;
        run_tile(4, 1'b0, 1'b0, 1'b0, exp_latency(4));   // recovery after reset

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
